// File: rtl/echo_sched_if.sv
// echo_sched_if: sample, tap-config, delay-RAM and wet-output signals of echo_sched.
interface echo_sched_if #(parameter int AW = 9);
    logic                 samp_clk;
    logic signed [15:0]   in_samp;
    logic [4*AW-1:0]      tap_dly;
    logic [11:0]          tap_shift;
    logic [AW-1:0]        mem_addr;
    logic                 mem_we;
    logic [15:0]          mem_wdata;
    logic [15:0]          mem_rdata;
    logic signed [15:0]   out_samp;
    logic                 out_valid;
    logic                 busy;
    logic                 overrun;
    modport master (output samp_clk, in_samp, tap_dly, tap_shift, mem_rdata,
                    input  mem_addr, mem_we, mem_wdata, out_samp, out_valid, busy, overrun);
    modport slave  (input  samp_clk, in_samp, tap_dly, tap_shift, mem_rdata,
                    output mem_addr, mem_we, mem_wdata, out_samp, out_valid, busy, overrun);
endinterface

// File: rtl/echo_sched.sv
// echo_sched: four-tap echo mixer over a single-port delay RAM.
// Define SATURATE_EN to clamp the mix to 16 bits instead of wrapping.
module echo_sched #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic        clk,
    input  logic        rst,
    echo_sched_if.slave io_bus
);
    typedef enum logic [2:0] {CLEAR, IDLE, READ, DRAIN, WRITE} state_t;
    state_t             r_state;
    logic [AW-1:0]      r_cnt, r_wr_ptr, r_addr;
    logic [1:0]         r_k;
    logic               r_we, r_valid, r_overrun;
    logic [15:0]        r_wdata;
    logic signed [15:0] r_out;
    logic signed [18:0] r_acc;
    logic [4*AW-1:0]    r_dly;
    logic [11:0]        r_shift;
    logic [1:0]         w_j, w_nk;
    logic [2:0]         w_sh;
    logic signed [18:0] w_rd, w_term, w_acc_nxt;
    logic [15:0]        w_mix;
    logic [AW-1:0]      w_next_addr;
    // read data returned this cycle belongs to the tap addressed one cycle earlier
    assign w_j         = r_k - 2'd1;
    assign w_nk        = r_k + 2'd1;
    assign w_sh        = r_shift[3*w_j +: 3];
    assign w_rd        = {{3{io_bus.mem_rdata[15]}}, io_bus.mem_rdata};
    assign w_term      = (w_sh == 3'd7) ? 19'sd0 : (w_rd >>> w_sh);
    assign w_acc_nxt   = r_acc + w_term;
    assign w_next_addr = r_wr_ptr - r_dly[w_nk*AW +: AW];
`ifdef SATURATE_EN
    assign w_mix = (w_acc_nxt > 19'sd32767) ? 16'h7FFF :
                   (w_acc_nxt < -19'sd32768) ? 16'h8000 : w_acc_nxt[15:0];
`else
    assign w_mix = w_acc_nxt[15:0];
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= CLEAR;
            r_cnt     <= '0;
            r_wr_ptr  <= '0;
            r_addr    <= '0;
            r_k       <= '0;
            r_we      <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_wdata   <= '0;
            r_out     <= '0;
            r_acc     <= '0;
            r_dly     <= '0;
            r_shift   <= '0;
        end else begin
            r_valid <= 1'b0;
            if (io_bus.samp_clk && r_state != IDLE) r_overrun <= 1'b1;
            case (r_state)
                CLEAR: begin
                    if (r_we && r_addr == AW'(DEPTH-1)) begin
                        r_state <= IDLE;
                        r_we    <= 1'b0;
                    end else begin
                        r_we   <= 1'b1;
                        r_addr <= r_cnt;
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                IDLE: if (io_bus.samp_clk) begin
                    r_dly   <= io_bus.tap_dly;
                    r_shift <= io_bus.tap_shift;
                    r_acc   <= {{3{io_bus.in_samp[15]}}, io_bus.in_samp};
                    r_addr  <= r_wr_ptr - io_bus.tap_dly[AW-1:0];
                    r_k     <= 2'd0;
                    r_state <= READ;
                end
                READ: begin
                    r_addr <= w_next_addr;
                    r_k    <= w_nk;
                    if (r_k != 2'd0) r_acc <= w_acc_nxt;
                    if (r_k == 2'd3) r_state <= DRAIN;
                end
                DRAIN: begin
                    r_acc   <= w_acc_nxt;
                    r_addr  <= r_wr_ptr;
                    r_we    <= 1'b1;
                    r_wdata <= w_mix;
                    r_state <= WRITE;
                end
                WRITE: begin
                    r_we     <= 1'b0;
                    r_out    <= r_wdata;
                    r_valid  <= 1'b1;
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign io_bus.mem_addr  = r_addr;
    assign io_bus.mem_we    = r_we;
    assign io_bus.mem_wdata = r_wdata;
    assign io_bus.out_samp  = r_out;
    assign io_bus.out_valid = r_valid;
    assign io_bus.busy      = (r_state != IDLE);
    assign io_bus.overrun   = r_overrun;
endmodule

// File: tb/tb_echo_sched.sv
// tb_echo_sched: directed checks of echo_sched against a behavioural delay RAM.
module tb_echo_sched;
    localparam int AW = 9;
    localparam int DEPTH = 512;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic prime = 1'b1;
    int checks = 0;
    int errors = 0;
    int n_ov = 0;
    logic [AW-1:0] last_wa = '0;
    logic [15:0] last_wd = '0;
    logic [15:0] ram [DEPTH];
    echo_sched_if #(.AW(AW)) bus ();
    echo_sched #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .io_bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (prime) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= 16'h5A5A;
        end else if (bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= ram[bus.mem_addr];
    end
    always @(negedge clk) begin
        if (bus.out_valid) n_ov++;
        if (bus.mem_we) begin
            last_wa = bus.mem_addr;
            last_wd = bus.mem_wdata;
        end
    end
    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic wait_clear(input string tag);
        int nw, bad, cyc, nz;
        nw = 0; bad = 0; cyc = 0; nz = 0;
        chk({tag, "_busy_start"}, bus.busy, 1);
        while (bus.busy && cyc < 700) begin
            @(negedge clk);
            cyc++;
            if (bus.mem_we) begin
                if (bus.mem_addr != nw[AW-1:0] || bus.mem_wdata != 16'd0) bad++;
                nw++;
            end
        end
        chk({tag, "_writes"}, nw, 512);
        chk({tag, "_addr_data"}, bad, 0);
        chk({tag, "_idle"}, bus.busy, 0);
        for (int i = 0; i < DEPTH; i++) if (ram[i] != 16'd0) nz++;
        chk({tag, "_ram_zero"}, nz, 0);
    endtask
    task automatic samp(input logic signed [15:0] s, input logic [4*AW-1:0] d, input logic [11:0] sh, output int lat);
        @(negedge clk);
        bus.samp_clk = 1'b1; bus.in_samp = s; bus.tap_dly = d; bus.tap_shift = sh;
        @(negedge clk);
        bus.samp_clk = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask
    task automatic run(input string tag, input logic signed [15:0] s, input logic [4*AW-1:0] d,
                       input logic [11:0] sh, input int exp, input int ptr);
        int lat;
        samp(s, d, sh, lat);
        chk({tag, "_lat"}, lat, 7);
        chk({tag, "_out"}, $signed(bus.out_samp), exp);
        chk({tag, "_waddr"}, last_wa, ptr);
        chk({tag, "_wdata"}, $signed(last_wd), exp);
        @(negedge clk);
        chk({tag, "_pulse"}, bus.out_valid, 0);
    endtask
    initial begin
        int lat, ov0, bad;
        bus.samp_clk = 1'b0; bus.in_samp = '0; bus.tap_dly = '0; bus.tap_shift = '0;
        repeat (3) @(negedge clk);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_out", $signed(bus.out_samp), 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_overrun", bus.overrun, 0);
        prime = 1'b0;
        rst = 1'b1;
        wait_clear("clear1");
        run("s1_muted", 16'sd1000, '0, 12'hFFF, 1000, 0);
        run("s2_half", 16'sd0, {9'd0, 9'd0, 9'd0, 9'd1}, 12'hFF9, 500, 1);
        run("s3_mix", -16'sd200, {9'd0, 9'd3, 9'd2, 9'd1}, {3'd0, 3'd0, 3'd0, 3'd2}, 925, 2);
        run("s4_neg", -16'sd3000, '0, 12'hFFF, -3000, 3);
        run("s5_floor", 16'sd100, {9'd3, 9'd2, 9'd4, 9'd1}, {3'd0, 3'd2, 3'd7, 3'd5}, 737, 4);
        repeat (3) @(negedge clk);
        chk("hold_out", $signed(bus.out_samp), 737);
        chk("idle_we", bus.mem_we, 0);
        chk("no_overrun", bus.overrun, 0);
        // second strobe lands while the first sample is in READ
        ov0 = n_ov;
        @(negedge clk); bus.samp_clk = 1'b1; bus.in_samp = 16'sd42; bus.tap_dly = '0; bus.tap_shift = 12'hFFF;
        @(negedge clk); bus.samp_clk = 1'b0;
        @(negedge clk); bus.samp_clk = 1'b1; bus.in_samp = 16'sd999;
        @(negedge clk); bus.samp_clk = 1'b0;
        chk("ovr_set", bus.overrun, 1);
        lat = 3;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("ovr_lat", lat, 7);
        chk("ovr_out", $signed(bus.out_samp), 42);
        repeat (12) @(negedge clk);
        chk("ovr_pulses", n_ov - ov0, 1);
        chk("ovr_sticky", bus.overrun, 1);
        chk("ovr_waddr", last_wa, 5);
        run("s7_big", 16'sd30000, '0, 12'hFFF, 30000, 6);
`ifdef SATURATE_EN
        run("s8_sat", 16'sd30000, {9'd0, 9'd0, 9'd0, 9'd1}, 12'hFF8, 32767, 7);
`else
        run("s8_wrap", 16'sd30000, {9'd0, 9'd0, 9'd0, 9'd1}, 12'hFF8, -5536, 7);
`endif
        chk("ovr_still", bus.overrun, 1);
        ov0 = n_ov;
        @(negedge clk); bus.samp_clk = 1'b1; bus.in_samp = 16'sd1234; bus.tap_dly = '0; bus.tap_shift = 12'hFFF;
        @(negedge clk); bus.samp_clk = 1'b0;
        @(negedge clk); rst = 1'b0;
        #1;
        chk("arst_out", $signed(bus.out_samp), 0);
        chk("arst_overrun", bus.overrun, 0);
        chk("arst_we", bus.mem_we, 0);
        chk("arst_addr", bus.mem_addr, 0);
        chk("arst_valid", bus.out_valid, 0);
        repeat (10) @(negedge clk);
        chk("arst_no_write", ram[8], 0);
        chk("arst_no_valid", n_ov - ov0, 0);
        rst = 1'b1;
        wait_clear("clear2");
        bad = 0;
        for (int i = 1; i <= 512; i++) begin
            samp(16'(i), '0, 12'hFF8, lat);
            if (lat != 7 || $signed(bus.out_samp) != i || last_wa != AW'(i - 1)) bad++;
        end
        chk("wrap_pass1", bad, 0);
        run("wrap_513", 16'sd513, '0, 12'hFF8, 514, 0);
        run("wrap_514", 16'sd0, '0, 12'hFF8, 2, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/echo_sched.md
ECHO_SCHED -- requirements
Module: echo_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 512, delay-memory words (power of two).
REQ-002 SHALL have parameter AW, default 9, address width, log2(DEPTH).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port samp_clk  input  1  one-cycle sample strobe.
REQ-006 SHALL have port in_samp  input  16  signed dry sample.
REQ-007 SHALL have port tap_dly  input  4*AW  four tap delays, tap k at [k*AW +: AW].
REQ-008 SHALL have port tap_shift  input  12  four 3-bit attenuation shifts, tap k at [3k +: 3].
REQ-009 SHALL have port mem_addr  output  AW  single-port RAM address.
REQ-010 SHALL have port mem_we  output  1  RAM write enable.
REQ-011 SHALL have port mem_wdata  output  16  RAM write data.
REQ-012 SHALL have port mem_rdata  input  16  RAM read data, valid one cycle after address.
REQ-013 SHALL have port out_samp  output  16  signed wet sample.
REQ-014 SHALL have port out_valid  output  1  one-cycle pulse, out_samp updated.
REQ-015 SHALL have port busy  output  1  high in CLEAR, READ, DRAIN, WRITE.
REQ-016 SHALL have port overrun  output  1  sticky; samp_clk seen while busy.

Function
REQ-017 SHALL implement states CLEAR, IDLE, READ, DRAIN, WRITE.
REQ-018 CLEAR SHALL write 0 to addresses 0..DEPTH-1, one per cycle, mem_we=1, then enter IDLE.
REQ-019 IDLE with samp_clk=1 SHALL latch in_samp, tap_dly, tap_shift, init acc=sign-extended in_samp (19 bit), enter READ with k=0.
REQ-020 READ SHALL drive mem_addr=(wr_ptr-tap_dly[k]) mod DEPTH for k=0..3, one per cycle, mem_we=0; tap_dly=0 reads wr_ptr (age DEPTH).
REQ-021 Each cycle after a read address, acc SHALL add (mem_rdata >>> shift_k) sign-extended; shift_k=7 SHALL contribute 0 (tap muted).
REQ-022 DRAIN SHALL accumulate tap 3 only, then enter WRITE.
REQ-023 WRITE SHALL drive mem_addr=wr_ptr, mem_we=1, mem_wdata=mix(acc); register out_samp=mix(acc), pulse out_valid next cycle, wr_ptr increments mod DEPTH, return to IDLE.
REQ-024 out_valid SHALL rise exactly 7 clk cycles after the cycle samp_clk was sampled high in IDLE.
REQ-025 samp_clk high in any busy state SHALL be ignored (no latch) and set overrun until reset.
REQ-026 wr_ptr SHALL wrap DEPTH-1 -> 0 without a stall.
REQ-027 out_samp SHALL hold between out_valid pulses; mem_we SHALL be 0 in IDLE, READ, DRAIN.

Reset
REQ-028 rst=0 SHALL asynchronously force: state CLEAR, clear counter 0, wr_ptr 0, out_samp 0, out_valid 0, overrun 0, mem_we 0, mem_addr 0, mem_wdata 0.
REQ-029 Reset asserted mid-sample SHALL abort with no RAM write; release SHALL restart full CLEAR.
REQ-030 busy SHALL be 1 during CLEAR after reset release.

Configuration
REQ-031 With SATURATE_EN defined, mix(acc) SHALL clamp to [-32768, 32767].
REQ-032 Without SATURATE_EN, mix(acc) SHALL be acc[15:0] (two's-complement wrap).

Verification
REQ-033 Reset release, DEPTH=512 -> busy high 512 cycles, mem_we high with addresses 0..511, data 0, then IDLE.
REQ-034 After clear, in_samp=1000, taps all shift 7, strobe -> out_samp=1000, out_valid 7 cycles after strobe, RAM[0]=1000.
REQ-035 tap_dly[0]=1, shift 1, others muted; strobe 1000 then 0 -> second out_samp=500, written to RAM[1].
REQ-036 Strobe during READ -> overrun=1 and stays 1, no extra out_valid, current sample completes normally.
REQ-037 in_samp=30000, tap0 rdata 30000 shift 0 -> out_samp=32767 with SATURATE_EN, -5536 without.
REQ-038 Run 513 samples with tap_dly[0]=0 -> wr_ptr wraps to 1, sample 513 reads sample 1's written value; reset mid-READ -> no write, CLEAR restarts.
